// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and decode-side handshake.
interface fetch_unit_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 13
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_valid;
  logic [INST_W-1:0] imem_data;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              inst_ready;
  logic              inst_valid;
  logic [INST_W-1:0] instOut;
  logic [PC_W-1:0]   inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, instOut, inst_pc,
    input  imem_valid, imem_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instOut, inst_pc,
    output imem_valid, imem_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// F stage: single-outstanding imem fetch into a small {pc,inst} FIFO feeding decode.
// Optional FETCH_STATS_EN adds saturating fetch_cnt / stall_cnt outputs.
module fetch_unit #(
  parameter int              PC_W      = 8,
  parameter int              INST_W    = 13,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic {S_ISSUE, S_WAIT} state_e;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             discard_q, discard_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  entry_t           buf_q [BUF_DEPTH];
  entry_t           head;
  logic             push, pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ISSUE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= '{pc: pc_q, inst: bus.imem_data};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ISSUE: if (bus.imem_req)   state_d = S_WAIT;
      S_WAIT:  if (bus.imem_valid) state_d = S_ISSUE;
      default: state_d = S_ISSUE;
    endcase
  end

  always_comb begin
    push      = (state_q == S_WAIT) && bus.imem_valid && !discard_q && !bus.redirect;
    pop       = bus.inst_valid && bus.inst_ready && !bus.redirect;
    pc_d      = pc_q;
    discard_d = discard_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (state_q == S_WAIT) begin
      if (bus.imem_valid)    discard_d = 1'b0;
      else if (bus.redirect) discard_d = 1'b1;
    end
    if (bus.redirect) begin
      pc_d     = bus.redirect_pc;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + PC_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    head           = buf_q[rd_ptr_q];
    bus.imem_req   = (state_q == S_ISSUE) && (cnt_q < DEPTH_C) && !bus.redirect && !rst;
    bus.imem_addr  = pc_q;
    bus.inst_valid = (cnt_q != '0);
    bus.instOut    = bus.inst_valid ? head.inst : '0;
    bus.inst_pc    = bus.inst_valid ? head.pc   : '0;
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (bus.inst_valid && !bus.inst_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural imem of selectable latency.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(8), .INST_W(13)) bus ();

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt, stall_cnt;
`endif

  fetch_unit #(.PC_W(8), .INST_W(13), .RESET_PC(8'h00), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // imem model: contents 13'h1000|addr except addr 0/1; lat cycles to respond
  logic [12:0] mem [256];
  int          lat = 1;
  logic [7:0]  req_log [$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 13'h1000 | 13'(i);
    mem[0] = 13'h1C35;
    mem[1] = 13'h0A47;
  end

  initial begin
    logic       req_s;
    logic [7:0] addr_s, pa;
    int         cnt;
    cnt = 0;
    pa  = '0;
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    forever begin
      @(posedge clk);
      req_s  = bus.imem_req;
      addr_s = bus.imem_addr;
      if (req_s) req_log.push_back(addr_s);
      @(negedge clk);
      bus.imem_valid = 1'b0;
      if (req_s) begin
        cnt = lat;
        pa  = addr_s;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_valid = 1'b1;
          bus.imem_data  = mem[pa];
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Returns in the first cycle after reset is released, outputs settled.
  task automatic do_reset();
    nxt();
    rst = 1'b1;
    #1;
    chk("rst_req_gated", 32'(bus.imem_req), 32'd0);
    repeat (2) nxt();
    chk("rst_empty", 32'(bus.inst_valid), 32'd0);
    rst = 1'b0;
    req_log.delete();
    #1;
  endtask

  initial begin
    logic found;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b1;

    // 1: basic fetch, 1-cycle memory
    lat = 1;
    do_reset();
    chk("t1_req0",      32'(bus.imem_req),   32'd1);
    chk("t1_addr0",     32'(bus.imem_addr),  32'h00);
    chk("t1_inst_rst",  32'(bus.instOut),    32'h0);
    chk("t1_pc_rst",    32'(bus.inst_pc),    32'h0);
    nxt();
    chk("t1_wait_req",  32'(bus.imem_req),   32'd0);
    chk("t1_wait_vld",  32'(bus.inst_valid), 32'd0);
    nxt();
    chk("t1_vld_a",     32'(bus.inst_valid), 32'd1);
    chk("t1_inst_a",    32'(bus.instOut),    32'h1C35);
    chk("t1_pc_a",      32'(bus.inst_pc),    32'h00);
    chk("t1_addr1",     32'(bus.imem_addr),  32'h01);
    nxt();
    chk("t1_gap_vld",   32'(bus.inst_valid), 32'd0);
    nxt();
    chk("t1_inst_b",    32'(bus.instOut),    32'h0A47);
    chk("t1_pc_b",      32'(bus.inst_pc),    32'h01);
    chk("t1_addr2",     32'(bus.imem_addr),  32'h02);

    // 2: decode stalled 10 cycles -> FIFO fills, issue stops
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (10) nxt();
    chk("t2_nreq",      32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) begin
      chk("t2_log0",    32'(req_log[0]),     32'h00);
      chk("t2_log1",    32'(req_log[1]),     32'h01);
    end
    chk("t2_req_off",   32'(bus.imem_req),   32'd0);
    chk("t2_head",      32'(bus.instOut),    32'h1C35);
    bus.inst_ready = 1'b1;
    nxt();
    chk("t2_head2",     32'(bus.instOut),    32'h0A47);
    chk("t2_head2_pc",  32'(bus.inst_pc),    32'h01);
    chk("t2_resume",    32'(bus.imem_req),   32'd1);
    chk("t2_resume_a",  32'(bus.imem_addr),  32'h02);

    // 3: redirect while waiting on addr 3 (2-cycle memory)
    lat = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr == 8'h03) found = 1'b1;
      else nxt();
    end
    chk("t3_reach_addr3", 32'(found), 32'd1);
    nxt();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    #1;
    chk("t3_req_during", 32'(bus.imem_req),  32'd0);
    nxt();
    bus.redirect = 1'b0;
    #1;
    chk("t3_flushed",   32'(bus.inst_valid), 32'd0);
    chk("t3_stale_req", 32'(bus.imem_req),   32'd0);
    nxt();
    chk("t3_req40",     32'(bus.imem_req),   32'd1);
    chk("t3_addr40",    32'(bus.imem_addr),  32'h40);
    repeat (3) nxt();
    chk("t3_vld40",     32'(bus.inst_valid), 32'd1);
    chk("t3_pc40",      32'(bus.inst_pc),    32'h40);
    chk("t3_inst40",    32'(bus.instOut),    32'h1040);

    // 4: redirect coinciding with imem_valid and a pop
    lat = 1;
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (3) nxt();
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h80;
    #1;
    chk("t4_pre_vld",   32'(bus.inst_valid), 32'd1);
    chk("t4_pre_resp",  32'(bus.imem_valid), 32'd1);
    nxt();
    bus.redirect = 1'b0;
    #1;
    chk("t4_empty",     32'(bus.inst_valid), 32'd0);
    chk("t4_req",       32'(bus.imem_req),   32'd1);
    chk("t4_addr80",    32'(bus.imem_addr),  32'h80);
    repeat (2) nxt();
    chk("t4_pc80",      32'(bus.inst_pc),    32'h80);
    chk("t4_inst80",    32'(bus.instOut),    32'h1080);

    // 5: redirect during issue to 8'hFF, PC wraps to 0
    do_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFF;
    #1;
    chk("t5_no_req",    32'(bus.imem_req),   32'd0);
    nxt();
    bus.redirect = 1'b0;
    #1;
    chk("t5_reqFF",     32'(bus.imem_addr),  32'hFF);
    chk("t5_reqFF_v",   32'(bus.imem_req),   32'd1);
    repeat (2) nxt();
    chk("t5_pcFF",      32'(bus.inst_pc),    32'hFF);
    chk("t5_instFF",    32'(bus.instOut),    32'h10FF);
    chk("t5_wrap",      32'(bus.imem_addr),  32'h00);
    chk("t5_wrap_v",    32'(bus.imem_req),   32'd1);

`ifdef FETCH_STATS_EN
    // 6: 3 stalled cycles then 5 pops
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (5) nxt();
    bus.inst_ready = 1'b1;
    repeat (8) nxt();
    chk("t6_fetch",     32'(fetch_cnt),      32'd5);
    chk("t6_stall",     32'(stall_cnt),      32'd3);
    bus.inst_ready = 1'b0;
    rst = 1'b1;
    nxt();
    chk("t6_fetch_rst", 32'(fetch_cnt),      32'd0);
    chk("t6_stall_rst", 32'(stall_cnt),      32'd0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
